// File: rtl/mfp_ahb_lite_boot_arbiter.sv
// Two-master AHB-Lite boot arbiter (loader / core) with phase-correct handover and core reset control.
// Optional build macro MFP_BOOT_ARB_STATS_EN adds the LoaderBeats completed-beat counter output.
module mfp_ahb_lite_boot_arbiter #(
  parameter int RESET_HOLD = 16,
  parameter int HOLD_W     = 5
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        loader_Busy,
  input  logic [31:0] loader_HADDR,
  input  logic [2:0]  loader_HBURST,
  input  logic        loader_HMASTLOCK,
  input  logic [3:0]  loader_HPROT,
  input  logic [2:0]  loader_HSIZE,
  input  logic [1:0]  loader_HTRANS,
  input  logic [31:0] loader_HWDATA,
  input  logic        loader_HWRITE,
  input  logic [31:0] cpu_HADDR,
  input  logic [2:0]  cpu_HBURST,
  input  logic        cpu_HMASTLOCK,
  input  logic [3:0]  cpu_HPROT,
  input  logic [2:0]  cpu_HSIZE,
  input  logic [1:0]  cpu_HTRANS,
  input  logic [31:0] cpu_HWDATA,
  input  logic        cpu_HWRITE,
  output logic [31:0] cpu_HRDATA,
  output logic        cpu_HREADY,
  output logic        cpu_HRESP,
  output logic [31:0] m_HADDR,
  output logic [2:0]  m_HBURST,
  output logic        m_HMASTLOCK,
  output logic [3:0]  m_HPROT,
  output logic [2:0]  m_HSIZE,
  output logic [1:0]  m_HTRANS,
  output logic [31:0] m_HWDATA,
  output logic        m_HWRITE,
  input  logic [31:0] m_HRDATA,
  input  logic        m_HREADY,
  input  logic        m_HRESP,
  output logic        MFP_Reset
`ifdef MFP_BOOT_ARB_STATS_EN
  ,
  output logic [31:0] LoaderBeats
`endif
);

  typedef enum logic [2:0] {LOAD, DRAIN, HOLD, RUN, PREEMPT} state_t;

  localparam logic OWN_LOADER = 1'b0;
  localparam logic OWN_CPU    = 1'b1;

  state_t            state;
  logic              dp_owner;
  logic              dp_valid;
  logic [HOLD_W-1:0] hold_cnt;
  logic              addr_owner;
  logic              addr_active;
  logic              pending;

  // PREEMPT keeps the CPU's control fields so the bus does not glitch while the CPU beat drains
  assign addr_owner  = (state == RUN) || (state == PREEMPT);
  assign addr_active = (state == LOAD) || (state == RUN);
  assign pending     = dp_valid & ~m_HREADY;

  assign m_HADDR     = addr_owner ? cpu_HADDR     : loader_HADDR;
  assign m_HBURST    = addr_owner ? cpu_HBURST    : loader_HBURST;
  assign m_HMASTLOCK = addr_owner ? cpu_HMASTLOCK : loader_HMASTLOCK;
  assign m_HPROT     = addr_owner ? cpu_HPROT     : loader_HPROT;
  assign m_HSIZE     = addr_owner ? cpu_HSIZE     : loader_HSIZE;
  assign m_HWRITE    = addr_owner ? cpu_HWRITE    : loader_HWRITE;
  assign m_HTRANS    = !addr_active ? 2'b00 : (addr_owner ? cpu_HTRANS : loader_HTRANS);

  assign m_HWDATA    = (dp_owner == OWN_CPU) ? cpu_HWDATA : loader_HWDATA;
  assign cpu_HRDATA  = m_HRDATA;
  assign cpu_HREADY  = (dp_owner == OWN_CPU) ? m_HREADY : 1'b1;
  assign cpu_HRESP   = (dp_owner == OWN_CPU) ? m_HRESP  : 1'b0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= LOAD;
      MFP_Reset <= 1'b1;
      dp_owner  <= OWN_LOADER;
      dp_valid  <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      if (m_HREADY) begin
        dp_valid <= m_HTRANS[1];
        dp_owner <= addr_owner;
      end
      case (state)
        LOAD: begin
          if (!loader_Busy) state <= DRAIN;
        end
        DRAIN: begin
          if (loader_Busy) begin
            state <= LOAD;
          end else if (!pending) begin
            state    <= HOLD;
            hold_cnt <= HOLD_W'(RESET_HOLD - 1);
          end
        end
        HOLD: begin
          if (loader_Busy) begin
            state <= LOAD;
          end else if (hold_cnt == '0) begin
            state     <= RUN;
            MFP_Reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        RUN: begin
          if (loader_Busy) begin
            state     <= PREEMPT;
            MFP_Reset <= 1'b1;
          end
        end
        PREEMPT: begin
          if (!pending) state <= LOAD;
        end
        default: begin
          state     <= LOAD;
          MFP_Reset <= 1'b1;
        end
      endcase
    end
  end

`ifdef MFP_BOOT_ARB_STATS_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      LoaderBeats <= '0;
    end else if (dp_valid && (dp_owner == OWN_LOADER) && m_HREADY && (LoaderBeats != 32'hFFFF_FFFF)) begin
      LoaderBeats <= LoaderBeats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mfp_ahb_lite_boot_arbiter.sv
// Scoreboard bench for mfp_ahb_lite_boot_arbiter: directed boot, drain, preempt and reset scenarios.
// Expected beats are queued by the stimulus; a negedge monitor pops and checks address and data phases.
module tb_mfp_ahb_lite_boot_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        loader_Busy = 1'b1;
  logic [31:0] loader_HADDR = '0;
  logic [2:0]  loader_HBURST = '0;
  logic        loader_HMASTLOCK = 1'b0;
  logic [3:0]  loader_HPROT = 4'h3;
  logic [2:0]  loader_HSIZE = 3'b010;
  logic [1:0]  loader_HTRANS = 2'b00;
  logic [31:0] loader_HWDATA = '0;
  logic        loader_HWRITE = 1'b0;
  logic [31:0] cpu_HADDR = 32'hBAD0_0000;
  logic [2:0]  cpu_HBURST = '0;
  logic        cpu_HMASTLOCK = 1'b1;
  logic [3:0]  cpu_HPROT = 4'h3;
  logic [2:0]  cpu_HSIZE = 3'b010;
  logic [1:0]  cpu_HTRANS = 2'b10;
  logic [31:0] cpu_HWDATA = '0;
  logic        cpu_HWRITE = 1'b1;
  logic [31:0] cpu_HRDATA;
  logic        cpu_HREADY;
  logic        cpu_HRESP;
  logic [31:0] m_HADDR;
  logic [2:0]  m_HBURST;
  logic        m_HMASTLOCK;
  logic [3:0]  m_HPROT;
  logic [2:0]  m_HSIZE;
  logic [1:0]  m_HTRANS;
  logic [31:0] m_HWDATA;
  logic        m_HWRITE;
  logic [31:0] m_HRDATA = '0;
  logic        m_HREADY = 1'b1;
  logic        m_HRESP = 1'b0;
  logic        MFP_Reset;
`ifdef MFP_BOOT_ARB_STATS_EN
  logic [31:0] LoaderBeats;
`endif

  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_boot_arbiter #(.RESET_HOLD(16), .HOLD_W(5)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .loader_Busy(loader_Busy),
    .loader_HADDR(loader_HADDR), .loader_HBURST(loader_HBURST), .loader_HMASTLOCK(loader_HMASTLOCK),
    .loader_HPROT(loader_HPROT), .loader_HSIZE(loader_HSIZE), .loader_HTRANS(loader_HTRANS),
    .loader_HWDATA(loader_HWDATA), .loader_HWRITE(loader_HWRITE),
    .cpu_HADDR(cpu_HADDR), .cpu_HBURST(cpu_HBURST), .cpu_HMASTLOCK(cpu_HMASTLOCK),
    .cpu_HPROT(cpu_HPROT), .cpu_HSIZE(cpu_HSIZE), .cpu_HTRANS(cpu_HTRANS),
    .cpu_HWDATA(cpu_HWDATA), .cpu_HWRITE(cpu_HWRITE),
    .cpu_HRDATA(cpu_HRDATA), .cpu_HREADY(cpu_HREADY), .cpu_HRESP(cpu_HRESP),
    .m_HADDR(m_HADDR), .m_HBURST(m_HBURST), .m_HMASTLOCK(m_HMASTLOCK), .m_HPROT(m_HPROT),
    .m_HSIZE(m_HSIZE), .m_HTRANS(m_HTRANS), .m_HWDATA(m_HWDATA), .m_HWRITE(m_HWRITE),
    .m_HRDATA(m_HRDATA), .m_HREADY(m_HREADY), .m_HRESP(m_HRESP),
    .MFP_Reset(MFP_Reset)
`ifdef MFP_BOOT_ARB_STATS_EN
    , .LoaderBeats(LoaderBeats)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t dp_beat;
  beat_t pop_beat;
  logic  dp_pend = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic write, input logic [31:0] data);
    beat_t b;
    b.addr = addr;
    b.write = write;
    b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Data phase completes before the next address phase is accepted in the same cycle
  always @(negedge HCLK) begin
    if (HRESET) begin
      dp_pend = 1'b0;
    end else if (m_HREADY) begin
      if (dp_pend) begin
        if (dp_beat.write) begin
          check("wdata", m_HWDATA, dp_beat.data);
        end else begin
          check("rdata", cpu_HRDATA, dp_beat.data);
          check("cpu_hready_rd", {31'd0, cpu_HREADY}, 32'd1);
        end
        $display("beat data   addr=%h write=%0d data=%h", dp_beat.addr, dp_beat.write, dp_beat.data);
        dp_pend = 1'b0;
      end
      if (m_HTRANS[1]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr %h, required no transfer", m_HADDR);
        end else begin
          pop_beat = exp_q.pop_front();
          check("addr", m_HADDR, pop_beat.addr);
          check("write", {31'd0, m_HWRITE}, {31'd0, pop_beat.write});
          dp_beat = pop_beat;
          dp_pend = 1'b1;
        end
      end
    end
  end

  task automatic loader_burst(input int n, input logic [31:0] base, input logic [31:0] dbase);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        loader_HTRANS = 2'b10;
        loader_HADDR  = base + 32'(4 * i);
        loader_HWRITE = 1'b1;
        push_exp(base + 32'(4 * i), 1'b1, dbase + 32'(i));
      end else begin
        loader_HTRANS = 2'b00;
      end
      if (i > 0) loader_HWDATA = dbase + 32'(i - 1);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset state; CPU is already driving a NONSEQ that must not reach the matrix
    repeat (2) tick();
    check("rst_MFP_Reset", {31'd0, MFP_Reset}, 32'd1);
    check("rst_m_HTRANS", {30'd0, m_HTRANS}, 32'd0);
    check("rst_cpu_HREADY", {31'd0, cpu_HREADY}, 32'd1);
    HRESET = 1'b0;
    tick();

    // 1: four loader writes
    loader_burst(4, 32'h1FC0_0000, 32'hA000_0000);
    check("load_MFP_Reset", {31'd0, MFP_Reset}, 32'd1);
    m_HRESP = 1'b1;
    #1;
    check("load_cpu_HRESP", {31'd0, cpu_HRESP}, 32'd0);
    m_HRESP = 1'b0;

    // 2/3: Busy falls with the last loader beat; its data phase stalls 3 cycles
    cpu_HADDR = 32'h8000_0000;
    cpu_HWRITE = 1'b1;
    loader_Busy = 1'b0;
    loader_HTRANS = 2'b10;
    loader_HADDR = 32'h1FC0_0010;
    push_exp(32'h1FC0_0010, 1'b1, 32'hA000_0004);
    tick();
    n = 0;
    loader_HTRANS = 2'b00;
    loader_HWDATA = 32'hA000_0004;
    m_HREADY = 1'b0;
    repeat (3) begin
      tick();
      n++;
    end
    m_HREADY = 1'b1;
    while (MFP_Reset && n < 60) begin
      check("drain_hold_m_HTRANS", {30'd0, m_HTRANS}, 32'd0);
      tick();
      n++;
    end
    check("boot_latency", n, 32'd20);
    $display("boot latency %0d cycles", n);
    push_exp(32'h8000_0000, 1'b1, 32'hC0DE_0001);
    check("run_first_m_HTRANS", {30'd0, m_HTRANS}, 32'd2);
    tick();

    // 4: CPU read stalled 2 cycles while the loader preempts
    cpu_HADDR = 32'h8000_0004;
    cpu_HWRITE = 1'b0;
    cpu_HWDATA = 32'hC0DE_0001;
    push_exp(32'h8000_0004, 1'b0, 32'hDA7A_0004);
    tick();
    cpu_HTRANS = 2'b00;
    m_HREADY = 1'b0;
    loader_Busy = 1'b1;
    loader_HTRANS = 2'b10;
    loader_HADDR = 32'h1FC0_0020;
    #1;
    check("stall_cpu_HREADY", {31'd0, cpu_HREADY}, 32'd0);
    tick();
    check("preempt_MFP_Reset", {31'd0, MFP_Reset}, 32'd1);
    check("preempt_m_HTRANS", {30'd0, m_HTRANS}, 32'd0);
    tick();
    m_HREADY = 1'b1;
    m_HRDATA = 32'hDA7A_0004;
    #1;
    check("preempt_last_m_HTRANS", {30'd0, m_HTRANS}, 32'd0);
    push_exp(32'h1FC0_0020, 1'b1, 32'hA000_0020);
    tick();
    check("reload_m_HTRANS", {30'd0, m_HTRANS}, 32'd2);
    tick();

    // 5: HRESET during a loader write wait state
    loader_HWDATA = 32'hA000_0020;
    loader_HADDR = 32'h1FC0_0024;
    push_exp(32'h1FC0_0024, 1'b1, 32'hA000_0024);
    tick();
    loader_HTRANS = 2'b00;
    loader_HWDATA = 32'hA000_0024;
    m_HREADY = 1'b0;
    #2;
    HRESET = 1'b1;
    #1;
    check("hreset_dp_valid", {31'd0, dut.dp_valid}, 32'd0);
    check("hreset_MFP_Reset", {31'd0, MFP_Reset}, 32'd1);
    tick();
    HRESET = 1'b0;
    m_HREADY = 1'b1;
    loader_HTRANS = 2'b10;
    loader_HADDR = 32'h1FC0_1000;
    #1;
    check("post_reset_m_HTRANS", {30'd0, m_HTRANS}, 32'd2);

    // 6: 100 loader beats, aborted hand-off, clean boot, then 3 CPU beats
    loader_burst(100, 32'h1FC0_1000, 32'hB000_0000);
`ifdef MFP_BOOT_ARB_STATS_EN
    check("loader_beats_100", LoaderBeats, 32'd100);
`endif
    loader_Busy = 1'b0;
    repeat (6) tick();
    loader_Busy = 1'b1;
    repeat (20) begin
      tick();
      check("abort_MFP_Reset", {31'd0, MFP_Reset}, 32'd1);
    end
    loader_Busy = 1'b0;
    tick();
    n = 0;
    while (MFP_Reset && n < 60) begin
      tick();
      n++;
    end
    check("boot_latency_nodrain", n, 32'd17);
    $display("boot latency %0d cycles", n);
    cpu_HWRITE = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin
        cpu_HTRANS = 2'b10;
        cpu_HADDR = 32'h8000_0100 + 32'(4 * i);
        push_exp(32'h8000_0100 + 32'(4 * i), 1'b1, 32'hC0DE_0100 + 32'(i));
      end else begin
        cpu_HTRANS = 2'b00;
      end
      if (i > 0) cpu_HWDATA = 32'hC0DE_0100 + 32'(i - 1);
      tick();
    end
    repeat (2) tick();
`ifdef MFP_BOOT_ARB_STATS_EN
    check("loader_beats_after_cpu", LoaderBeats, 32'd100);
`endif
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
